// File: rtl/action_set_ctrl_if.sv
// AXI-stream bundle used on both sides of action_set_ctrl.
// Master drives payload and tvalid, slave returns tready.
interface action_set_ctrl_if #(
  parameter int DATA_W = 600,
  parameter int KEEP_W = DATA_W / 8,
  parameter int ID_W   = 8,
  parameter int DEST_W = 4,
  parameter int USER_W = 6
);
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [ID_W-1:0]   tid;
  logic [DEST_W-1:0] tdest;
  logic [USER_W-1:0] tuser;

  modport master (
    output tdata, tkeep, tvalid, tlast,
    output tid, tdest, tuser,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tvalid, tlast,
    input  tid, tdest, tuser,
    output tready
  );
endinterface

// File: rtl/action_set_ctrl.sv
// Binds queued {en,data} descriptors to packets and emits set_data per beat.
// Optional ACTION_SET_CTRL_STATS_EN adds popped-descriptor counters.
module action_set_ctrl #(
  parameter int S_DATA_WIDTH    = 600,
  parameter int S_KEEP_WIDTH    = S_DATA_WIDTH / 8,
  parameter int S_ID_WIDTH      = 8,
  parameter int S_DEST_WIDTH    = 4,
  parameter int S_USER_WIDTH    = 6,
  parameter int SET_DATA_WIDTH  = 8,
  parameter int SET_ADDR_OFFSET = 0,
  parameter int ACT_FIFO_DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [SET_DATA_WIDTH-1:0] s_act_data,
  input  logic                      s_act_en,
  input  logic                      s_act_valid,
  output logic                      s_act_ready,
  action_set_ctrl_if.slave          s_axis,
  action_set_ctrl_if.master         m_axis,
  output logic [SET_DATA_WIDTH-1:0] set_data,
  output logic                      busy
`ifdef ACTION_SET_CTRL_STATS_EN
  ,
  output logic [31:0]               stat_pkt_set,
  output logic [31:0]               stat_pkt_bypass
`endif
);

  localparam int AW = (ACT_FIFO_DEPTH > 1) ?
                      $clog2(ACT_FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    BODY
  } state_t;

  state_t state, state_nx;

  logic [SET_DATA_WIDTH:0]   mem [ACT_FIFO_DEPTH];
  logic [AW-1:0]             wr_ptr, rd_ptr;
  logic [CW-1:0]             count;
  logic                      push, pop, full, empty;
  logic                      accept, head_en;
  logic [SET_DATA_WIDTH-1:0] head_data;

  logic [S_DATA_WIDTH-1:0]   m_data_q;
  logic [S_KEEP_WIDTH-1:0]   m_keep_q;
  logic                      m_valid_q, m_last_q;
  logic [S_ID_WIDTH-1:0]     m_id_q;
  logic [S_DEST_WIDTH-1:0]   m_dest_q;
  logic [S_USER_WIDTH-1:0]   m_user_q;
  logic [SET_DATA_WIDTH-1:0] set_q;

  assign full        = (count == CW'(ACT_FIFO_DEPTH));
  assign empty       = (count == '0);
  assign s_act_ready = !full;
  assign push        = s_act_valid && !full;
  assign {head_en, head_data} = mem[rd_ptr];

  assign s_axis.tready = (state != IDLE) &&
                         (!m_valid_q || m_axis.tready);
  assign accept = s_axis.tvalid && s_axis.tready;
  assign busy   = (state != IDLE) || !empty;

  assign m_axis.tdata  = m_data_q;
  assign m_axis.tkeep  = m_keep_q;
  assign m_axis.tvalid = m_valid_q;
  assign m_axis.tlast  = m_last_q;
  assign m_axis.tid    = m_id_q;
  assign m_axis.tdest  = m_dest_q;
  assign m_axis.tuser  = m_user_q;
  assign set_data      = set_q;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {s_act_en, s_act_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state decision uses the pre-pop count; a same-cycle push
  // becomes visible one cycle later via IDLE.
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) state_nx = FIRST;
      end
      FIRST, BODY: begin
        if (accept) begin
          if (s_axis.tlast) begin
            pop      = 1'b1;
            state_nx = (count > CW'(1)) ? FIRST : IDLE;
          end else begin
            state_nx = BODY;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_keep_q  <= '0;
      m_last_q  <= 1'b0;
      m_id_q    <= '0;
      m_dest_q  <= '0;
      m_user_q  <= '0;
      set_q     <= '0;
    end else if (accept) begin
      m_valid_q <= 1'b1;
      m_data_q  <= s_axis.tdata;
      m_keep_q  <= s_axis.tkeep;
      m_last_q  <= s_axis.tlast;
      m_id_q    <= s_axis.tid;
      m_dest_q  <= s_axis.tdest;
      m_user_q  <= s_axis.tuser;
      set_q     <= (state == FIRST && head_en) ? head_data :
                   s_axis.tdata[SET_ADDR_OFFSET +: SET_DATA_WIDTH];
    end else if (m_axis.tready) begin
      m_valid_q <= 1'b0;
    end
  end

`ifdef ACTION_SET_CTRL_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_pkt_set    <= '0;
      stat_pkt_bypass <= '0;
    end else if (pop) begin
      if (head_en && stat_pkt_set != '1)
        stat_pkt_set <= stat_pkt_set + 32'd1;
      if (!head_en && stat_pkt_bypass != '1)
        stat_pkt_bypass <= stat_pkt_bypass + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_action_set_ctrl.sv
// Scoreboard bench for action_set_ctrl.
// Stats checks apply when ACTION_SET_CTRL_STATS_EN is defined.
module tb_action_set_ctrl;
  localparam int DW    = 32;
  localparam int KW    = 4;
  localparam int IW    = 8;
  localparam int DSW   = 4;
  localparam int UW    = 6;
  localparam int SW    = 8;
  localparam int OFF   = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [SW-1:0] act_data;
  logic          act_en, act_valid, act_ready;
  logic [SW-1:0] set_data;
  logic          busy;
`ifdef ACTION_SET_CTRL_STATS_EN
  logic [31:0]   stat_pkt_set, stat_pkt_bypass;
`endif

  action_set_ctrl_if #(.DATA_W(DW), .KEEP_W(KW), .ID_W(IW),
    .DEST_W(DSW), .USER_W(UW)) s_if ();
  action_set_ctrl_if #(.DATA_W(DW), .KEEP_W(KW), .ID_W(IW),
    .DEST_W(DSW), .USER_W(UW)) m_if ();

  action_set_ctrl #(
    .S_DATA_WIDTH(DW), .S_KEEP_WIDTH(KW), .S_ID_WIDTH(IW),
    .S_DEST_WIDTH(DSW), .S_USER_WIDTH(UW),
    .SET_DATA_WIDTH(SW), .SET_ADDR_OFFSET(OFF),
    .ACT_FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_act_data(act_data), .s_act_en(act_en),
    .s_act_valid(act_valid), .s_act_ready(act_ready),
    .s_axis(s_if), .m_axis(m_if),
    .set_data(set_data), .busy(busy)
`ifdef ACTION_SET_CTRL_STATS_EN
    , .stat_pkt_set(stat_pkt_set),
    .stat_pkt_bypass(stat_pkt_bypass)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0]  data;
    logic [KW-1:0]  keep;
    logic           last;
    logic [IW-1:0]  id;
    logic [DSW-1:0] dest;
    logic [UW-1:0]  user;
    logic [SW-1:0]  set;
  } beat_t;

  beat_t sb[$];
  beat_t mon_e;
  int errors = 0;
  int checks = 0;

  always @(negedge clk) begin
    if (rst_n && m_if.tvalid && m_if.tready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: got tdata=%h, required none",
                 m_if.tdata);
      end else begin
        mon_e = sb.pop_front();
        if ({m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tid,
             m_if.tdest, m_if.tuser} !==
            {mon_e.data, mon_e.keep, mon_e.last, mon_e.id,
             mon_e.dest, mon_e.user}) begin
          errors++;
          $display("FAIL beat_payload: got %h/%h/%b id=%h, required %h/%h/%b id=%h",
                   m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tid,
                   mon_e.data, mon_e.keep, mon_e.last, mon_e.id);
        end
        checks++;
        if (set_data !== mon_e.set) begin
          errors++;
          $display("FAIL set_data: got %h, required %h",
                   set_data, mon_e.set);
        end
      end
    end
  end

  task automatic drive_beat(input logic last, input logic [IW-1:0] id,
                            input int idx);
    s_if.tvalid = 1'b1;
    s_if.tdata  = $urandom;
    s_if.tkeep  = KW'($urandom);
    s_if.tlast  = last;
    s_if.tid    = id;
    s_if.tdest  = DSW'(idx);
    s_if.tuser  = UW'(id + IW'(idx));
  endtask

  task automatic push_exp(input logic [SW-1:0] set);
    beat_t e;
    e.data = s_if.tdata;
    e.keep = s_if.tkeep;
    e.last = s_if.tlast;
    e.id   = s_if.tid;
    e.dest = s_if.tdest;
    e.user = s_if.tuser;
    e.set  = set;
    sb.push_back(e);
  endtask

  task automatic wait_tready(output logic ok);
    int n = 0;
    @(negedge clk);
    while (!s_if.tready && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = s_if.tready;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got tready=0, required 1");
    end
  endtask

  task automatic push_desc(input logic en, input logic [SW-1:0] d);
    int n = 0;
    act_valid = 1'b1;
    act_en    = en;
    act_data  = d;
    @(negedge clk);
    while (!act_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!act_ready) begin
      checks++;
      errors++;
      $display("FAIL desc_timeout: got act_ready=0, required 1");
    end
    @(posedge clk); #1;
    act_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic en, input logic [SW-1:0] d,
                          input int nb, input logic [IW-1:0] id);
    logic ok;
    for (int i = 0; i < nb; i++) begin
      drive_beat(i == nb - 1, id, i);
      wait_tready(ok);
      if (!ok) begin
        s_if.tvalid = 1'b0;
        return;
      end
      push_exp((i == 0 && en) ? d : s_if.tdata[OFF +: SW]);
      @(posedge clk); #1;
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic drain();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({m_if.tvalid, m_if.tdata, m_if.tlast, set_data, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b d=%h set=%h busy=%b, required all 0",
               m_if.tvalid, m_if.tdata, set_data, busy);
    end
    checks++;
    if (s_if.tready !== 1'b0) begin
      errors++;
      $display("FAIL reset_tready: got %b, required 0", s_if.tready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (act_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got ready=%b busy=%b, required 1/0",
               act_ready, busy);
    end
  endtask

  task automatic test_set_field();
    push_desc(1'b1, 8'hAB);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_queued: got %b, required 1", busy);
    end
    send_pkt(1'b1, 8'hAB, 3, 8'h01);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_pop: got busy=%b, required 0", busy);
    end
    drain();
  endtask

  task automatic test_no_desc();
    int cyc = 0;
    drive_beat(1'b1, 8'h02, 0);
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (s_if.tready !== 1'b0) begin
        errors++;
        $display("FAIL stall_no_desc: got tready=%b, required 0",
                 s_if.tready);
      end
    end
    @(posedge clk); #1;
    act_valid = 1'b1;
    act_en    = 1'b1;
    act_data  = 8'h3C;
    @(posedge clk); #1;
    act_valid = 1'b0;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (s_if.tready) break;
    end
    checks++;
    if (cyc != 2 || !s_if.tready) begin
      errors++;
      $display("FAIL first_accept_latency: got %0d cycles, required 2",
               cyc);
    end
    push_exp(8'h3C);
    @(posedge clk); #1;
    s_if.tvalid = 1'b0;
    drain();
  endtask

  task automatic test_back_to_back();
    logic ok;
    for (int i = 0; i < DEPTH; i++)
      push_desc(1'(i % 2), SW'(8'h10 + i));
    act_valid = 1'b1;
    act_en    = 1'b1;
    act_data  = 8'hEE;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (act_ready !== 1'b0) begin
        errors++;
        $display("FAIL fifo_full: got act_ready=%b, required 0",
                 act_ready);
      end
    end
    @(posedge clk); #1;
    act_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive_beat(1'b1, IW'(8'h20 + i), 0);
      @(negedge clk);
      checks++;
      if (s_if.tready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_bubble: pkt %0d got tready=%b, required 1",
                 i, s_if.tready);
        wait_tready(ok);
      end
      push_exp((i % 2) ? SW'(8'h10 + i) : s_if.tdata[OFF +: SW]);
      @(posedge clk); #1;
    end
    s_if.tvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: got busy=%b, required 0", busy);
    end
    drain();
  endtask

  task automatic test_backpressure();
    push_desc(1'b1, 8'h5A);
    fork
      send_pkt(1'b1, 8'h5A, 4, 8'h03);
      begin
        int n = 0;
        logic [DW+KW+IW+DSW+UW+SW+1:0] snap;
        @(negedge clk);
        while (!m_if.tvalid && n < 50) begin
          @(negedge clk);
          n++;
        end
        @(posedge clk); #1;
        m_if.tready = 1'b0;
        snap = {m_if.tvalid, m_if.tdata, m_if.tkeep, m_if.tlast,
                m_if.tid, m_if.tdest, m_if.tuser, set_data};
        repeat (5) begin
          @(negedge clk);
          checks++;
          if ({m_if.tvalid, m_if.tdata, m_if.tkeep, m_if.tlast,
               m_if.tid, m_if.tdest, m_if.tuser, set_data} !== snap
              || m_if.tvalid !== 1'b1) begin
            errors++;
            $display("FAIL hold_stable: got v=%b d=%h set=%h, required v=1 held",
                     m_if.tvalid, m_if.tdata, set_data);
          end
          checks++;
          if (s_if.tready !== 1'b0) begin
            errors++;
            $display("FAIL hold_tready: got %b, required 0",
                     s_if.tready);
          end
        end
        @(posedge clk); #1;
        m_if.tready = 1'b1;
      end
    join
    drain();
  endtask

  task automatic test_bypass();
`ifdef ACTION_SET_CTRL_STATS_EN
    logic [31:0] byp0, set0;
    byp0 = stat_pkt_bypass;
    set0 = stat_pkt_set;
`endif
    push_desc(1'b0, 8'hCC);
    send_pkt(1'b0, 8'hCC, 3, 8'h04);
    drain();
`ifdef ACTION_SET_CTRL_STATS_EN
    checks++;
    if (stat_pkt_bypass !== byp0 + 32'd1 || stat_pkt_set !== set0) begin
      errors++;
      $display("FAIL stats_bypass: got byp=%0d set=%0d, required %0d/%0d",
               stat_pkt_bypass, stat_pkt_set, byp0 + 32'd1, set0);
    end
`endif
  endtask

  task automatic test_reset_mid();
    logic ok;
    push_desc(1'b1, 8'h77);
    push_desc(1'b0, 8'h66);
    drive_beat(1'b0, 8'h05, 0);
    wait_tready(ok);
    push_exp(8'h77);
    @(posedge clk); #1;
    drive_beat(1'b0, 8'h05, 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (m_if.tvalid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got tvalid=%b busy=%b, required 0/0",
               m_if.tvalid, busy);
    end
    s_if.tvalid = 1'b0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (act_ready !== 1'b1 || busy !== 1'b0 || m_if.tvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_release: got ready=%b busy=%b v=%b, required 1/0/0",
               act_ready, busy, m_if.tvalid);
    end
    push_desc(1'b1, 8'h12);
    send_pkt(1'b1, 8'h12, 2, 8'h06);
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    act_valid   = 1'b0;
    act_en      = 1'b0;
    act_data    = '0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tkeep  = '0;
    s_if.tlast  = 1'b0;
    s_if.tid    = '0;
    s_if.tdest  = '0;
    s_if.tuser  = '0;
    m_if.tready = 1'b1;
    test_reset();
    test_set_field();
    test_no_desc();
    test_back_to_back();
    test_backpressure();
    test_bypass();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %0d pending, required 0",
               sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
